cordic_share_arb: RTL and testbench
===================================

Name: cordic_share_arb

Overview:
- Lets NREQ independent requesters share one pipelined Cordic instance (rotation mode, DW/AW/ITER parameters).
- Arbitrates requests round-robin, registers the granted operands into the Cordic inputs, and carries a requester tag through a delay line aligned to the Cordic latency.
- Returns each result with the ID of the requester that issued it.
- Sits beside the Cordic in DDS/mixer/polar-conversion subsystems. The Cordic is instantiated by the parent, not inside this block.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 10, Cordic x/y data width, Q1.(DW-1).
- AW, DW, Cordic angle width, Q1.(AW-1), where [-1,1) maps to [-pi,pi).
- ITER, DW, Cordic stage count. Must equal the instantiated Cordic's ITER.
- LAT, ITER+1, Cordic latency in enabled clocks (stages plus output register).
- IDW, $clog2(NREQ), tag width (minimum 1).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  per-requester grant, one-hot or zero
- req_x  in  NREQ*DW  packed x operands, requester i at [i*DW +: DW]
- req_y  in  NREQ*DW  packed y operands
- req_a  in  NREQ*AW  packed angles
- cor_en  out  1  Cordic enable
- cor_xin  out  DW  registered operand to Cordic xin
- cor_yin  out  DW  registered operand to Cordic yin
- cor_ain  out  AW  registered angle to Cordic ain
- cor_xout  in  DW  Cordic xout
- cor_yout  in  DW  Cordic yout
- cor_arem  in  AW  Cordic arem
- res_valid  out  1  result valid
- res_id  out  IDW  requester index of current result
- res_x  out  DW  result x, combinational from cor_xout
- res_y  out  DW  result y, combinational from cor_yout
- res_a  out  AW  residual angle, combinational from cor_arem
- res_rdy  in  1  downstream accept (used only with the optional feature)
- busy  out  1  high while any operation is in flight

Behaviour:
- Reset (rst high at an edge):
  - cor_xin/yin/ain = 0; tag pipe valids = 0; res_valid = 0; res_id = 0; busy = 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Parent drives the Cordic's rst from the same rst.
  - Reset mid-operation discards every in-flight operation; no res_valid appears for them.
- Arbitration (combinational):
  - When cor_en=1, grant the first requester with req_valid high, searching from ptr+1 upward with wrap.
  - req_ready[g]=1 for that requester only. req_ready is all-zero when no request or cor_en=0.
  - At most one handshake per cycle.
- Issue, at a handshake edge (req_valid[g] & req_ready[g]):
  - cor_xin/yin/ain <= requester g operands; ptr <= g.
  - Tag pipe entry 0 <= {valid=1, id=g}.
- No-issue cycle with cor_en=1: tag entry 0 <= valid=0. Operand registers hold their value (don't-care).
- Tag pipe:
  - LAT+1 entries; shifts one entry per edge with cor_en=1; holds when cor_en=0.
  - res_valid and res_id = last entry.
- Latency: a handshake in cycle 0 gives res_valid in cycle LAT+1 (cycle 12 with defaults). Throughput is 1 per cycle.
- Results return strictly in issue order. No reordering or buffering.
- busy = OR of all tag valids.
- Fairness: a continuously asserting requester is served at least once every NREQ grants.
- Requester-side rules:
  - A requester may drop req_valid without a handshake.
  - Operands are sampled only at the handshake edge.
- Width rules: operands pass unmodified, with no scaling or saturation. Angle encoding is Q1.(AW-1).

Optional Feature:
- Macro: CORDIC_SHARE_ARB_STALL_EN.
- Defined:
  - cor_en = ~(res_valid & ~res_rdy). A result not accepted freezes the Cordic, the tag pipe and issue (req_ready all zero).
  - res_valid and res_x/y/a hold stable until res_rdy=1; then everything advances on that edge.
  - rst overrides the stall.
- Undefined:
  - cor_en tied to 1 and res_rdy ignored.
  - Each result is presented for exactly one cycle.

Test Plan (defaults NREQ=4, DW=AW=ITER=10, LAT=11):
- Single request: req 2, x=500, y=0, a=0, handshake cycle 0 -> res_valid only in cycle 12, res_id=2, res_x=500±4, res_y=0±4; busy high cycles 1-12.
- Angle: req 0, x=500, y=0, a=256 (pi/2) -> res_x=0±4, res_y=500±4, res_id=0, cycle 12.
- Round-robin: all four requesting continuously from reset -> grants 0,1,2,3,0,1... one per cycle; res_id sequence 0,1,2,3,... starting cycle 12; no gaps.
- Fairness: req 1 and req 3 always valid, req 2 pulsed once -> req 2 granted within 4 grants; req 1 and req 3 alternate otherwise.
- Reset mid-flight: 5 issues, rst in cycle 6 -> no res_valid ever for those 5; ptr restarts at 0; busy=0 after the reset edge.
- (STALL_EN) res_rdy=0 for cycles 12-15 with back-to-back traffic -> res_valid held, res_id/res_x stable, req_ready=0 in cycles 12-15; order and values intact after release; no result lost or duplicated.

Source files
------------

// File: rtl/cordic_share_arb.sv
// cordic_share_arb: round-robin share of one pipelined Cordic; each result returns with its requester id LAT+1 cycles after the handshake.
// Backpressure only with CORDIC_SHARE_ARB_STALL_EN (unaccepted result freezes Cordic, tag pipe and issue); otherwise res_rdy is ignored.
module cordic_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 10,
  parameter int AW   = DW,
  parameter int ITER = DW,
  parameter int LAT  = ITER + 1,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_x,
  input  logic [NREQ*DW-1:0]   req_y,
  input  logic [NREQ*AW-1:0]   req_a,
  output logic                 cor_en,
  output logic [DW-1:0]        cor_xin,
  output logic [DW-1:0]        cor_yin,
  output logic [AW-1:0]        cor_ain,
  input  logic [DW-1:0]        cor_xout,
  input  logic [DW-1:0]        cor_yout,
  input  logic [AW-1:0]        cor_arem,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [DW-1:0]        res_x,
  output logic [DW-1:0]        res_y,
  output logic [AW-1:0]        res_a,
  input  logic                 res_rdy,
  output logic                 busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]  xin_q, xin_d;
  logic [DW-1:0]  yin_q, yin_d;
  logic [AW-1:0]  ain_q, ain_d;
  logic [LAT:0]   tag_vld_q, tag_vld_d;
  logic [IDW-1:0] tag_id_q [LAT+1];
  logic [IDW-1:0] tag_id_d [LAT+1];

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           hs;

`ifdef CORDIC_SHARE_ARB_STALL_EN
  assign cor_en = ~(res_valid & ~res_rdy);
`else
  logic unused_res_rdy;
  assign unused_res_rdy = res_rdy;
  assign cor_en         = 1'b1;
`endif

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign hs        = grant_vld & cor_en;
  assign req_ready = hs ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d     = ptr_q;
    xin_d     = xin_q;
    yin_d     = yin_q;
    ain_d     = ain_q;
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    // The tag pipe advances in lockstep with the Cordic stages.
    if (cor_en) begin
      tag_vld_d   = {tag_vld_q[LAT-1:0], hs};
      tag_id_d[0] = grant_idx;
      for (int i = 1; i <= LAT; i++) begin
        tag_id_d[i] = tag_id_q[i-1];
      end
    end
    if (hs) begin
      ptr_d = grant_idx;
      xin_d = req_x[int'(grant_idx)*DW +: DW];
      yin_d = req_y[int'(grant_idx)*DW +: DW];
      ain_d = req_a[int'(grant_idx)*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= IDW'(NREQ - 1);
      xin_q     <= '0;
      yin_q     <= '0;
      ain_q     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      xin_q     <= xin_d;
      yin_q     <= yin_d;
      ain_q     <= ain_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  assign cor_xin   = xin_q;
  assign cor_yin   = yin_q;
  assign cor_ain   = ain_q;
  assign res_valid = tag_vld_q[LAT];
  assign res_id    = tag_id_q[LAT];
  assign res_x     = cor_xout;
  assign res_y     = cor_yout;
  assign res_a     = cor_arem;
  assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_cordic_share_arb.sv
// Bench for cordic_share_arb with an ideal stand-in Cordic (arem echoes the input angle so operand routing is exactly observable).
module tb_cordic_share_arb;
  localparam int NREQ = 4;
  localparam int DW   = 10;
  localparam int AW   = 10;
  localparam int ITER = 10;
  localparam int LAT  = ITER + 1;
  localparam int IDW  = 2;
  localparam real PI  = 3.14159265358979323846;

  logic clk;
  logic rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic [NREQ*AW-1:0] req_a;
  logic               cor_en;
  logic [DW-1:0]      cor_xin, cor_yin, cor_xout, cor_yout;
  logic [AW-1:0]      cor_ain, cor_arem;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [DW-1:0]      res_x, res_y;
  logic [AW-1:0]      res_a;
  logic               res_rdy;
  logic               busy;

  cordic_share_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .ITER(ITER), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_a(req_a),
    .cor_en(cor_en), .cor_xin(cor_xin), .cor_yin(cor_yin), .cor_ain(cor_ain),
    .cor_xout(cor_xout), .cor_yout(cor_yout), .cor_arem(cor_arem),
    .res_valid(res_valid), .res_id(res_id), .res_x(res_x), .res_y(res_y), .res_a(res_a),
    .res_rdy(res_rdy), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rot_x(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [AW-1:0] a);
    real th;
    th = $itor($signed(a)) * PI / $itor(1 << (AW - 1));
    return DW'($rtoi($floor($itor($signed(x)) * $cos(th) - $itor($signed(y)) * $sin(th) + 0.5)));
  endfunction

  function automatic logic [DW-1:0] rot_y(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [AW-1:0] a);
    real th;
    th = $itor($signed(a)) * PI / $itor(1 << (AW - 1));
    return DW'($rtoi($floor($itor($signed(x)) * $sin(th) + $itor($signed(y)) * $cos(th) + 0.5)));
  endfunction

  // Stand-in Cordic: LAT enabled stages, cleared by the shared reset.
  logic [DW-1:0] sx_q [LAT];
  logic [DW-1:0] sy_q [LAT];
  logic [AW-1:0] sa_q [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
        sa_q[i] <= '0;
      end
    end else if (cor_en) begin
      sx_q[0] <= rot_x(cor_xin, cor_yin, cor_ain);
      sy_q[0] <= rot_y(cor_xin, cor_yin, cor_ain);
      sa_q[0] <= cor_ain;
      for (int i = 1; i < LAT; i++) begin
        sx_q[i] <= sx_q[i-1];
        sy_q[i] <= sy_q[i-1];
        sa_q[i] <= sa_q[i-1];
      end
    end
  end
  assign cor_xout = sx_q[LAT-1];
  assign cor_yout = sy_q[LAT-1];
  assign cor_arem = sa_q[LAT-1];

  typedef struct { int id; int x; int y; int a; int age; } op_t;
  typedef struct { int cyc; int id; int x; int y; int a; } obs_t;

  op_t  inflight[$];
  obs_t obs[$];
  int   grants[$];
  int   mptr;
  int   cyc;
  int   checks;
  int   failures;
  int   issued;
  int   accepted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_op(input int r, input int x, input int y, input int a);
    req_x[r*DW +: DW] = DW'(x);
    req_y[r*DW +: DW] = DW'(y);
    req_a[r*AW +: AW] = AW'(a);
  endtask

  task automatic rand_ops();
    for (int r = 0; r < NREQ; r++) begin
      set_op(r, $urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300, $urandom_range(0, (1 << AW) - 1));
    end
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model at the rising edge.
  task automatic tick();
    bit                 exp_vld, exp_en, crst;
    int                 exp_g, want_rdy;
    logic [NREQ-1:0]    cv;
    logic [NREQ*DW-1:0] cx, cy;
    logic [NREQ*AW-1:0] ca;
    op_t                h, n;
    obs_t               o;
    @(negedge clk);
    crst = rst; cv = req_valid; cx = req_x; cy = req_y; ca = req_a;
    exp_vld = (inflight.size() > 0) && (inflight[0].age == LAT + 1);
`ifdef CORDIC_SHARE_ARB_STALL_EN
    exp_en = !(exp_vld && !res_rdy);
`else
    exp_en = 1'b1;
`endif
    exp_g = -1;
    if (exp_en) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (exp_g < 0 && cv[(mptr + k) % NREQ]) exp_g = (mptr + k) % NREQ;
      end
    end
    want_rdy = (exp_g < 0) ? 0 : (1 << exp_g);
    chk("cor_en", cor_en, exp_en);
    chk("req_ready", req_ready, want_rdy);
    chk("busy", busy, inflight.size() > 0);
    chk("res_valid", res_valid, exp_vld);
    if (exp_vld && res_valid) begin
      h = inflight[0];
      chk("res_id", res_id, h.id);
      chk("res_x", res_x, rot_x(DW'(h.x), DW'(h.y), AW'(h.a)));
      chk("res_y", res_y, rot_y(DW'(h.x), DW'(h.y), AW'(h.a)));
      chk("res_a", res_a, h.a);
    end
    if (res_valid && res_rdy) begin
      o.cyc = cyc; o.id = res_id; o.x = res_x; o.y = res_y; o.a = res_a;
      obs.push_back(o);
      accepted++;
    end
    for (int r = 0; r < NREQ; r++) if (req_ready[r]) grants.push_back(r);
    @(posedge clk);
    if (crst) begin
      inflight.delete();
      mptr = NREQ - 1;
    end else if (exp_en) begin
      foreach (inflight[i]) inflight[i].age++;
      if (inflight.size() > 0 && inflight[0].age > LAT + 1) void'(inflight.pop_front());
      if (exp_g >= 0) begin
        n.id = exp_g; n.age = 1;
        n.x = int'(cx[exp_g*DW +: DW]);
        n.y = int'(cy[exp_g*DW +: DW]);
        n.a = int'(ca[exp_g*AW +: AW]);
        inflight.push_back(n);
        mptr = exp_g;
        issued++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int t0;
  int waited;
  bit got2;

  initial begin
    checks = 0; failures = 0; cyc = 0; mptr = NREQ - 1; issued = 0; accepted = 0;
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_a = '0; res_rdy = 1'b1;
    do_reset();

    // Single request from requester 2, zero angle.
    obs.delete();
    set_op(2, 500, 0, 0);
    req_valid = 4'b0100; t0 = cyc; tick(); req_valid = '0;
    repeat (14) tick();
    chk("single_count", obs.size(), 1);
    if (obs.size() > 0) begin
      chk("single_cycle", obs[0].cyc, t0 + 12);
      chk("single_id", obs[0].id, 2);
      chk("single_x", obs[0].x, 500);
      chk("single_y", obs[0].y, 0);
    end

    // Quarter turn from requester 0.
    obs.delete();
    set_op(0, 500, 0, 256);
    req_valid = 4'b0001; t0 = cyc; tick(); req_valid = '0;
    repeat (14) tick();
    chk("angle_count", obs.size(), 1);
    if (obs.size() > 0) begin
      chk("angle_cycle", obs[0].cyc, t0 + 12);
      chk("angle_id", obs[0].id, 0);
      chk("angle_x", obs[0].x, 0);
      chk("angle_y", obs[0].y, 500);
      chk("angle_a", obs[0].a, 256);
    end

    // All requesters continuously from reset.
    do_reset();
    obs.delete(); grants.delete();
    req_valid = '1; t0 = cyc;
    for (int c = 0; c < 24; c++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (LAT + 2) tick();
    for (int i = 0; i < 8; i++) chk("rr_grant", (i < grants.size()) ? grants[i] : -1, i % NREQ);
    chk("rr_first_res", (obs.size() > 0) ? obs[0].cyc : -1, t0 + 12);
    for (int i = 0; i < 8; i++) begin
      chk("rr_res_id", (i < obs.size()) ? obs[i].id : -1, i % NREQ);
      chk("rr_res_gap", (i < obs.size()) ? obs[i].cyc : -1, t0 + 12 + i);
    end

    // Requesters 1 and 3 always on, requester 2 raised until served.
    do_reset();
    grants.delete();
    req_valid = 4'b1010;
    repeat (3) tick();
    req_valid[2] = 1'b1; waited = 0; got2 = 1'b0;
    for (int i = 0; i < 8 && !got2; i++) begin
      tick();
      waited++;
      if (grants.size() > 0 && grants[grants.size()-1] == 2) got2 = 1'b1;
    end
    req_valid[2] = 1'b0;
    chk("fair_served", {31'd0, got2}, 1);
    chk("fair_wait_ok", waited <= NREQ, 1);
    grants.delete();
    repeat (6) tick();
    for (int i = 1; i < 6; i++) begin
      if (i < grants.size()) chk("fair_alt", grants[i], (grants[i-1] == 1) ? 3 : 1);
    end
    req_valid = '0;
    repeat (LAT + 2) tick();

    // Reset with five operations in flight.
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    tick();
    obs.delete();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("flush_xin", cor_xin, 0);
    chk("flush_ain", cor_ain, 0);
    chk("flush_busy", busy, 0);
    repeat (LAT + 4) tick();
    chk("flush_no_res", obs.size(), 0);
    grants.delete();
    req_valid = '1; tick(); req_valid = '0;
    chk("ptr_restart", (grants.size() > 0) ? grants[0] : -1, 0);
    repeat (LAT + 2) tick();

`ifdef CORDIC_SHARE_ARB_STALL_EN
    // Downstream holds off results 12..15 cycles after the first issue.
    do_reset();
    issued = 0; accepted = 0;
    req_valid = '1;
    for (int c = 0; c < 30; c++) begin
      rand_ops();
      res_rdy = !(c >= 12 && c <= 15);
      tick();
    end
    req_valid = '0; res_rdy = 1'b1;
    repeat (LAT + 6) tick();
    chk("stall_count", accepted, issued);
`endif

    // Randomized traffic.
    do_reset();
    issued = 0; accepted = 0;
    for (int c = 0; c < 600; c++) begin
      req_valid = NREQ'($urandom);
      rand_ops();
`ifdef CORDIC_SHARE_ARB_STALL_EN
      res_rdy = ($urandom_range(0, 3) != 0);
`endif
      tick();
    end
    req_valid = '0; res_rdy = 1'b1;
    repeat (LAT + 6) tick();
    chk("rand_count", accepted, issued);
    chk("rand_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
